// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory slave: command codes, FSM states, counter sizing.
package spi_mem_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCmd    = 3'd1,
    StWrAddr = 3'd2,
    StWrData = 3'd3,
    StRdAddr = 3'd4,
    StRdData = 3'd5,
    StWait   = 3'd6
  } state_e;

  // Bit counter must hold values up to the longer of the two payload lengths.
  function automatic int unsigned cnt_width(int unsigned aw, int unsigned dw);
    int unsigned m;
    m = (aw > dw) ? aw : dw;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_mem_slave_gen2_if.sv
// SPI pin bundle between host (master) and the memory slave.
interface spi_mem_slave_gen2_if;
  logic MOSI;
  logic SS_n;
  logic MISO;
  logic busy;

  modport master (output MOSI, output SS_n, input MISO, input busy);
  modport slave  (input MOSI, input SS_n, output MISO, output busy);
endinterface

// File: rtl/spi_mem_ram.sv
// Single-clock RAM, synchronous write and synchronous read, contents not reset.
module spi_mem_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/spi_mem_slave_gen2.sv
// SPI slave front end with embedded RAM, generic address/data widths.
// Define SPI_MEM_BURST_EN for auto-incrementing multi-word data frames.
module spi_mem_slave_gen2
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_mem_slave_gen2_if.slave bus
);
  localparam int unsigned SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = cnt_width(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic              cmd_hi_q, cmd_hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d, sh_in;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_buf_q, ram_rdata;
  logic              miso_q, miso_d;
  logic              busy_q;
  logic              ram_we;

  always_comb begin
    state_d  = state_q;
    cmd_hi_d = cmd_hi_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    miso_d   = 1'b0;
    ram_we   = 1'b0;
    sh_in    = {sh_q[SH_W-2:0], bus.MOSI};
    // Deasserted select always aborts: partial words are simply dropped.
    if (bus.SS_n) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cmd_hi_d = bus.MOSI;
          state_d  = StCmd;
        end
        StCmd: begin
          cnt_d = '0;
          case ({cmd_hi_q, bus.MOSI})
            CMD_WR_ADDR: state_d = StWrAddr;
            CMD_WR_DATA: state_d = StWrData;
            CMD_RD_ADDR: state_d = StRdAddr;
            CMD_RD_DATA: begin
              // MSB goes out on the same edge that decodes the command.
              state_d = StRdData;
              miso_d  = rd_buf_q[DATA_W-1];
              tx_d    = rd_buf_q << 1;
`ifdef SPI_MEM_BURST_EN
              rd_ptr_d = rd_ptr_q + 1'b1;
`endif
            end
            default: state_d = StIdle;
          endcase
        end
        StWrAddr, StRdAddr: begin
          sh_d = sh_in;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = StWait;
            if (state_q == StWrAddr) wr_ptr_d = sh_in[ADDR_W-1:0];
            else                     rd_ptr_d = sh_in[ADDR_W-1:0];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWrData: begin
          sh_d = sh_in;
          if (cnt_q == DATA_LAST) begin
            ram_we = 1'b1;
            cnt_d  = '0;
`ifdef SPI_MEM_BURST_EN
            wr_ptr_d = wr_ptr_q + 1'b1;
`else
            state_d = StWait;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRdData: begin
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
`ifdef SPI_MEM_BURST_EN
            // rd_buf already holds the next word, fetched after the last increment.
            miso_d   = rd_buf_q[DATA_W-1];
            tx_d     = rd_buf_q << 1;
            rd_ptr_d = rd_ptr_q + 1'b1;
`else
            state_d = StWait;
`endif
          end else begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
        StWait: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cmd_hi_q <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
      tx_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_buf_q <= '0;
      miso_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_hi_q <= cmd_hi_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_buf_q <= ram_rdata;
      miso_q   <= miso_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  // Read address looks ahead so rd_buf tracks mem[rd_ptr] one edge after a pointer load.
  spi_mem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (sh_in[DATA_W-1:0]),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  assign bus.MISO = miso_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_spi_mem_slave_gen2.sv
// Scoreboard bench: 8/8 instance for the main flows, 10/16 instance for wide words.
module tb_spi_mem_slave_gen2;
  import spi_mem_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] ss_n;
  logic [1:0] mosi;
  logic [1:0] miso;
  logic [1:0] busy;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0]  model0 [256];
  logic [15:0] model1 [1024];
  logic [31:0] exp_q [$];
  logic        last_tail;

  spi_mem_slave_gen2_if bus0 ();
  spi_mem_slave_gen2_if bus1 ();

  assign bus0.MOSI = mosi[0];
  assign bus0.SS_n = ss_n[0];
  assign miso[0]   = bus0.MISO;
  assign busy[0]   = bus0.busy;
  assign bus1.MOSI = mosi[1];
  assign bus1.SS_n = ss_n[1];
  assign miso[1]   = bus1.MISO;
  assign busy[1]   = bus1.busy;

  spi_mem_slave_gen2 #(.ADDR_W(8), .DATA_W(8)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  spi_mem_slave_gen2 #(.ADDR_W(10), .DATA_W(16)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One SS_n frame: drive on negedge, sample MISO on negedge after each DUT edge.
  task automatic frame(input int sel, input logic [1:0] cmd, input logic [31:0] payload,
                       input int nbits, output logic [31:0] got, output logic tail);
    got = '0;
    @(negedge clk);
    ss_n[sel] = 1'b0;
    mosi[sel] = cmd[1];
    @(negedge clk);
    mosi[sel] = cmd[0];
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      got = {got[30:0], miso[sel]};
      mosi[sel] = payload[nbits-1-k];
    end
    @(negedge clk);
    tail = miso[sel];
    ss_n[sel] = 1'b1;
    mosi[sel] = 1'b0;
  endtask

  task automatic wr(input int sel, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] g;
    logic t;
    frame(sel, CMD_WR_ADDR, addr, (sel == 0) ? 8 : 10, g, t);
    frame(sel, CMD_WR_DATA, data, (sel == 0) ? 8 : 16, g, t);
    if (sel == 0) model0[addr[7:0]] = data[7:0];
    else          model1[addr[9:0]] = data[15:0];
  endtask

  task automatic rd(input int sel, input logic [31:0] addr, input string tag);
    logic [31:0] g;
    logic [31:0] e;
    logic t;
    frame(sel, CMD_RD_ADDR, addr, (sel == 0) ? 8 : 10, g, t);
    exp_q.push_back((sel == 0) ? 32'(model0[addr[7:0]]) : 32'(model1[addr[9:0]]));
    frame(sel, CMD_RD_DATA, 32'h0, (sel == 0) ? 8 : 16, g, t);
    e = exp_q.pop_front();
    check_eq(tag, g, e);
    last_tail = t;
  endtask

  initial begin
    logic [31:0] g;
    logic [31:0] e;
    logic        t;
    logic [7:0]  v;

    rst_n = 1'b0;
    ss_n  = 2'b11;
    mosi  = 2'b00;
    repeat (3) @(negedge clk);
    check_eq("rst_miso0", 32'(miso[0]), 32'h0);
    check_eq("rst_busy0", 32'(busy[0]), 32'h0);
    check_eq("rst_miso1", 32'(miso[1]), 32'h0);
    rst_n = 1'b1;

    wr(0, 32'h00, 32'h33);
    wr(0, 32'h10, 32'h77);
    wr(0, 32'h05, 32'h12);
    rd(0, 32'h10, "pre_rd_10");

    // Reset after five payload bits of a WR_DATA 0x5A to address 0x10.
    frame(0, CMD_WR_ADDR, 32'h10, 8, g, t);
    v = 8'h5A;
    @(negedge clk);
    ss_n[0] = 1'b0;
    mosi[0] = CMD_WR_DATA[1];
    @(negedge clk);
    mosi[0] = CMD_WR_DATA[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mosi[0] = v[7-k];
    end
    @(negedge clk);
    check_eq("busy_mid", 32'(busy[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_miso", 32'(miso[0]), 32'h0);
    check_eq("rst_mid_busy", 32'(busy[0]), 32'h0);
    ss_n[0] = 1'b1;
    mosi[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // rd_ptr is back at 0, so a bare RD_DATA returns mem[0].
    exp_q.push_back(32'(model0[0]));
    frame(0, CMD_RD_DATA, 32'h0, 8, g, t);
    e = exp_q.pop_front();
    check_eq("rd_noaddr", g, e);
    rd(0, 32'h10, "rst_no_write");

    // Abort after four bits of WR_DATA 0xFF.
    frame(0, CMD_WR_ADDR, 32'h05, 8, g, t);
    frame(0, CMD_WR_DATA, 32'hF, 4, g, t);
    check_eq("abort_miso", 32'(miso[0]), 32'h0);
    @(negedge clk);
    check_eq("abort_busy", 32'(busy[0]), 32'h0);
    rd(0, 32'h05, "abort_keep");

    for (int i = 100; i < 200; i++) wr(0, 32'(i), 32'(11 * (((i - 100) % 23) + 1)));
    for (int i = 100; i < 200; i++) rd(0, 32'(i), "sweep");

    wr(1, 32'h3FF, 32'hBEEF);
    rd(1, 32'h3FF, "wide_beef");
`ifndef SPI_MEM_BURST_EN
    check_eq("wide_len", 32'(last_tail), 32'h0);
`endif

`ifdef SPI_MEM_BURST_EN
    frame(0, CMD_WR_ADDR, 32'hFE, 8, g, t);
    frame(0, CMD_WR_DATA, 32'hA1A2A3, 24, g, t);
    model0[8'hFE] = 8'hA1;
    model0[8'hFF] = 8'hA2;
    model0[8'h00] = 8'hA3;
    frame(0, CMD_RD_ADDR, 32'hFE, 8, g, t);
    exp_q.push_back(32'(model0[8'hFE]));
    exp_q.push_back(32'(model0[8'hFF]));
    exp_q.push_back(32'(model0[8'h00]));
    frame(0, CMD_RD_DATA, 32'h0, 24, g, t);
    e = exp_q.pop_front();
    check_eq("burst_w0", 32'(g[23:16]), e);
    e = exp_q.pop_front();
    check_eq("burst_w1", 32'(g[15:8]), e);
    e = exp_q.pop_front();
    check_eq("burst_w2", 32'(g[7:0]), e);
    rd(0, 32'h00, "burst_wrap");
`endif

    @(negedge clk);
    check_eq("end_busy", 32'(busy[0]), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_mem_slave_gen2.md
Name: spi_mem_slave_gen2

Overview:
Parametrised successor to the team's SPI-slave + single-port RAM memory block, which was fixed at 8-bit address and 8-bit data. This block has one clock and is a single-slave SPI front end with embedded RAM. Address and data widths are generic. Under a compile macro it adds auto-incrementing burst transfers, so several words move per SS_n frame. It is the host-facing memory peripheral at top level.

Parameters:
ADDR_W, 8, address width; RAM depth is the localparam DEPTH = 2**ADDR_W.
DATA_W, 8, word width; also the shift length of data phases.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst_n  in  1  asynchronous active-low reset.
MOSI  in  1  serial data in, MSB first, sampled on posedge clk.
SS_n  in  1  active-low slave select; the frame is the interval while low.
MISO  out  1  serial data out, registered, driven from posedge clk.
busy  out  1  high while a frame is in progress (state not IDLE).

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: MISO=0, busy=0, state=IDLE, wr_ptr=0, rd_ptr=0, rd_buf=0, shift counters=0. RAM contents are not cleared.
- Frame format: 2-bit CMD (MSB first), then payload. Encodings: 00 WR_ADDR (ADDR_W bits in), 01 WR_DATA (DATA_W bits in), 10 RD_ADDR (ADDR_W bits in), 11 RD_DATA (DATA_W bits out on MISO).
- Each bit is captured on the posedge where SS_n=0. The first posedge with SS_n=0 captures CMD[1].
- States: IDLE -> CMD (on SS_n=0) -> WR_ADDR | WR_DATA | RD_ADDR | RD_DATA (after CMD[0]) -> WAIT (payload complete) -> IDLE (when SS_n=1).
- WAIT ignores MOSI. MISO=0 in every state except RD_DATA.
- WR_ADDR: the last address bit loads wr_ptr on that same edge.
- WR_DATA: on the edge capturing the last bit, mem[wr_ptr] <= word. The write is visible to a read-address fetch from the next cycle.
- RD_ADDR: the last bit loads rd_ptr. On the next edge, rd_buf <= mem[rd_ptr] (prefetch).
- RD_DATA: on the edge capturing CMD[0], MISO <= rd_buf[DATA_W-1]. Bit i is then driven on each later edge, so bit 0 appears DATA_W-1 edges later. The host samples on negedge.
- Zero bubble: MISO carries MSB on the same edge that captures CMD[0].
- SS_n rising mid-frame: state goes to IDLE on that edge. The partial shift register is discarded; no pointer or RAM update occurs. MISO returns to 0 on that edge.
- RD_DATA with no prior RD_ADDR returns mem[rd_ptr] using the reset value of rd_ptr (0).
- Pointer arithmetic is modulo DEPTH: DEPTH-1 increments to 0.
- SS_n low again on the edge right after returning to IDLE starts a new frame. A one-cycle SS_n high is sufficient.
- busy = (state != IDLE); it is registered.

Optional Feature:
Macro SPI_MEM_BURST_EN.
- Defined:
  - WR_DATA and RD_DATA do not enter WAIT; they loop while SS_n=0.
  - WR_DATA: each completed word is written to mem[wr_ptr], then wr_ptr increments (wrapping).
  - RD_DATA: rd_ptr increments and the next word is fetched during the current word. MSB of word k+1 is driven on the edge after LSB of word k, with no gap.
  - An incomplete trailing word is discarded.
- Undefined: exactly one word per frame; pointers never auto-increment.

Decomposition:
- Package spi_mem_pkg:
  - CMD encodings as localparams: CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA.
  - State encoding constants.
  - Width of the bit counter: clog2 of max(ADDR_W, DATA_W)+1.
- Sub-module spi_mem_ram (ADDR_W, DATA_W): synchronous write port and synchronous read port, no reset. The top holds the FSM, shift registers and pointers.

Test Plan:
- Reset mid-frame: assert rst_n=0 after 5 payload bits of WR_DATA 0x5A at addr 0x10. Required: MISO=0 and busy=0 immediately; a later read of 0x10 does not return 0x5A.
- Default widths, addresses 100..199 with data 11,22,...,253 wrapping back to 11. Do WR_ADDR+WR_DATA per address, then RD_ADDR+RD_DATA per address. Required: every read matches, with the MSB sampled at the negedge after the CMD[0] capture edge.
- ADDR_W=10, DATA_W=16: write 0xBEEF to 0x3FF, read it back. Required: 0xBEEF appears on MISO over exactly 16 bits.
- Abort: raise SS_n after 4 bits of WR_DATA 0xFF to addr 5 (previously 0x12). Required: a read of addr 5 returns 0x12.
- Read without RD_ADDR after reset, with mem[0]=0x33 written first. Required: RD_DATA returns 0x33.
- Burst (SPI_MEM_BURST_EN): WR_ADDR 0xFE, then one WR_DATA frame of 0xA1,0xA2,0xA3. Then RD_ADDR 0xFE and a 24-bit RD_DATA frame. Required:
  - Reads 0xA1,0xA2,0xA3 contiguously.
  - Wrap confirmed: mem[0x00]=0xA3.
